// File: rtl/arf_pkg.sv
// Shared constants and sizing helpers for the arf sink buffer.
package arf_pkg;

    localparam int ARF_DATA_WIDTH    = 32;
    localparam int ARF_DEFAULT_DEPTH = 4;

    // Pointer width; a 2-entry FIFO still needs one address bit.
    function automatic int ptr_width(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // The occupancy must also represent the full value DEPTH.
    function automatic int level_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    localparam int ARF_LEVEL_WIDTH = level_width(ARF_DEFAULT_DEPTH);

endpackage

// File: rtl/arf_sink_mem.sv
// FIFO storage: register array with synchronous write and combinational head read.
module arf_sink_mem
    import arf_pkg::*;
#(
    parameter int DATA_WIDTH = ARF_DATA_WIDTH,
    parameter int DEPTH      = ARF_DEFAULT_DEPTH,
    parameter int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/arf_sink_buffer.sv
// Drains an arf output port via req/ack into a FIFO and presents it as a valid/ready stream.
// Optional stall/starve counters are enabled by defining ARF_SINK_STALL_STATS_EN.
module arf_sink_buffer
    import arf_pkg::*;
#(
    parameter int DATA_WIDTH = ARF_DATA_WIDTH,
    parameter int DEPTH      = ARF_DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          req,
    input  logic                          ack,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [level_width(DEPTH)-1:0] level,
    output logic [CNT_WIDTH-1:0]          count,
    output logic                          overflow
`ifdef ARF_SINK_STALL_STATS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   starve_cycles
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  req_q, req_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  push_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Reading at the next read pointer lets the head be registered for the following cycle.
    arf_sink_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_d),
        .rdata (mem_rdata)
    );

    always_comb begin
        pop        = m_valid_q & m_ready;
        push_acc   = ack & ((level_q != LW'(DEPTH)) | pop);
        wr_ptr_d   = wr_ptr_q + PW'(push_acc);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_d    = level_q + LW'(push_acc) - LW'(pop);
        req_d      = (level_d <= LW'(DEPTH - 2));
        m_valid_d  = (level_d != '0);
        count_d    = count_q + CNT_WIDTH'(push_acc);
        overflow_d = overflow_q | (ack & ~push_acc);
        m_data_d   = m_data_q;
        // The new head is the word being written only when the FIFO would otherwise be empty.
        if (m_valid_d) begin
            m_data_d = (push_acc && (wr_ptr_q == rd_ptr_d)) ? din : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            req_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            req_q      <= req_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign req      = req_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign level    = level_q;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef ARF_SINK_STALL_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] starve_q, starve_d;

    always_comb begin
        stall_d  = stall_q + 32'(m_valid_q & ~m_ready);
        starve_d = starve_q + 32'(req_q & ~ack & (level_q == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign starve_cycles = starve_q;
`endif

endmodule

// File: doc/arf_sink_buffer.md
Name: arf_sink_buffer

Overview:
- Drain stage sitting directly downstream of an arf dataflow output port (`dout_req_N` / `dout_ack_N` / `dout_N`).
- Pulls results using the arf req/ack protocol, buffers them in a DEPTH-entry FIFO, and presents them on a valid/ready stream to the next consumer or host interface.
- Keeps a 32-bit count of accepted words and a sticky overflow flag, so benches can measure throughput as they do today.

Parameters:
- DATA_WIDTH, 32: width of arf output data and stream data.
- DEPTH, 4: FIFO entries. Power of two, minimum 2.
- CNT_WIDTH, 32: width of the `count` output.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset. 0 resets the block; must be released synchronously to clk.
- req, output, 1: request to arf out operator (drives `dout_req_N`).
- ack, input, 1: one-cycle acknowledge from arf (`dout_ack_N`).
- din, input, DATA_WIDTH: arf output data, valid while ack=1.
- m_valid, output, 1: stream data valid.
- m_ready, input, 1: downstream ready.
- m_data, output, DATA_WIDTH: stream data (FIFO head).
- level, output, clog2(DEPTH)+1: current occupancy.
- count, output, CNT_WIDTH: words accepted from arf since reset.
- overflow, output, 1: sticky, set when an ack arrived with no free slot.

Behaviour:
- Reset (rst=0, asynchronous): req=0, m_valid=0, m_data=0, level=0, count=0, overflow=0, read and write pointers=0.
- push = ack. pop = m_valid & m_ready. occ_next = level + push_accepted − pop.
- req is registered. At each edge: `req <= (occ_next <= DEPTH-2)`.
  - An ack is only legal in the cycle after req was sampled high, so at most one ack per cycle can land in the reserved slot.
  - With no downstream stall, this guarantees no overflow.
- Push rules:
  - ack=1 and (level<DEPTH or pop this cycle): din is written at the write pointer, write pointer increments (wraps at DEPTH), count increments.
  - count wraps modulo 2^CNT_WIDTH.
  - ack=1, level==DEPTH and no pop: data dropped, count unchanged, overflow<=1 (sticky until reset).
  - ack while req was low (spurious) is still accepted if space exists; no error is raised.
- Pop: m_data/m_valid reflect the FIFO head from registered storage.
  - Pop advances the read pointer (wraps at DEPTH).
  - m_valid stays high while level>0.
- Latency: word acked in cycle c appears on m_valid/m_data in cycle c+1. There is no same-cycle bypass from din to m_data.
- Empty: m_valid=0, m_data holds its last value.
- Full: req=0, m_valid=1.
- Simultaneous push and pop at full: both proceed, level stays DEPTH.
- Simultaneous push and pop at empty cannot occur (m_valid=0).
- m_data/m_valid are stable while m_valid=1 and m_ready=0.
- Reset mid-operation: FIFO contents are discarded and all outputs return to reset values immediately. The first req rises one cycle after rst deasserts.

Optional Feature:
- Macro: ARF_SINK_STALL_STATS_EN.
- Defined: adds two outputs.
  - stall_cycles (32 bits): increments every cycle with m_valid=1 and m_ready=0.
  - starve_cycles (32 bits): increments every cycle with req=1, ack=0 and level==0.
  - Both reset to 0 and wrap modulo 2^32.
- Not defined: these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Package arf_pkg holds:
  - the default DATA_WIDTH constant (32);
  - a ptr_width function, clog2 with minimum 1;
  - a localparam computing level width.
- One sub-module, arf_sink_mem: DEPTH×DATA_WIDTH register array with write enable/address and asynchronous read of the head address, no reset on the array.
- Pointer, level, req and counter logic stay in arf_sink_buffer.

Test Plan:
- Reset, then m_ready=1 and the arf model acks every other cycle with din=0,1,2,… → m_data sequence 0,1,2,… in order. count=1000 after 1000 acks, overflow=0, level ≤ 1.
- DEPTH=4, m_ready=0, continuous acks honoring req → req drops when occ_next reaches 3. Level saturates at 4 with no drop, overflow=0. Raising m_ready then drains values 0..3 in order.
- Force ack=1 while level==4 and m_ready=0, din=0xDEAD → overflow=1 and stays 1. count is unchanged, and 0xDEAD never appears on m_data.
- Level=4, m_ready=1 with ack=1 in the same cycle → level stays 4, count increments, overflow stays 0. The popped word is the oldest entry.
- Assert rst=0 mid-burst at level=3, then release → req, m_valid, level and count read 0 the same cycle. req=1 one cycle after release, and the prior data is never emitted.
- With ARF_SINK_STALL_STATS_EN: hold m_ready=0 for 10 cycles with m_valid=1 → stall_cycles=10. Without the macro, the block elaborates without the extra ports.
